// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the execute-stage multiply/divide engine: operation codes,
// FSM states and small decode helpers.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Bit 1 selects divide, bit 0 selects the unsigned variant.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative restoring divider on magnitudes; resolves DIV_STEP quotient bits per enabled
// cycle and presents sign-corrected results combinationally during the final iteration.
module ex_muldiv_unit_div_core #(
  parameter int DATA_W   = 32,
  parameter int DIV_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] abs_a,
  input  logic [DATA_W-1:0] abs_b,
  input  logic              neg_q,
  input  logic              neg_r,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int N  = DATA_W / DIV_STEP;
  localparam int CW = $clog2(N) + 1;

  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q_q, neg_r_q;
  logic [DATA_W-1:0] r_c, q_c;
  logic [DATA_W+1:0] trial;

  // quo_q starts as the dividend and fills with quotient bits from the right.
  always_comb begin
    r_c   = rem_q;
    q_c   = quo_q;
    trial = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      trial = {1'b0, r_c, q_c[DATA_W-1]} - {2'b00, dvs_q};
      if (!trial[DATA_W+1]) begin
        r_c = trial[DATA_W-1:0];
        q_c = {q_c[DATA_W-2:0], 1'b1};
      end else begin
        r_c = {r_c[DATA_W-2:0], q_c[DATA_W-1]};
        q_c = {q_c[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (load) begin
      rem_q   <= '0;
      quo_q   <= abs_a;
      dvs_q   <= abs_b;
      cnt_q   <= '0;
      neg_q_q <= neg_q;
      neg_r_q <= neg_r;
    end else if (en) begin
      rem_q <= r_c;
      quo_q <= q_c;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done      = en && (cnt_q == CW'(N - 1));
  assign quotient  = neg_q_q ? -q_c : q_c;
  assign remainder = neg_r_q ? -r_c : r_c;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide engine producing a HI/LO pair with a stall-held done pulse.
// Optional MULDIV_EARLY_OUT_EN finishes trivial divides right after operand capture.
import ex_muldiv_unit_pkg::*;

module ex_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_STEP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              is_busbusy,
  output logic              busy,
  output logic              opreat_over,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_zero,
  output logic [1:0]        dbg_state
);

  localparam int PIPE = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  md_state_t           state, state_nxt, launch_state;
  logic                accept, op_div, signed_op, neg_a, b_zero, early_out;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] ext_a, ext_b, product, mul_result;
  logic [2*DATA_W-1:0] mul_pipe [PIPE];
  logic [1:0]          mul_cnt_q;
  logic [DATA_W-1:0]   a_q;
  logic                bz_q;
  logic                div_done;
  logic [DATA_W-1:0]   div_quo, div_rem;
  logic                complete, res_dz;
  logic [DATA_W-1:0]   res_hi, res_lo;

  assign op_div    = is_div_op(op);
  assign signed_op = is_signed_op(op);
  assign neg_a     = signed_op & src_a[DATA_W-1];
  assign abs_a     = neg_a ? -src_a : src_a;
  assign abs_b     = (signed_op & src_b[DATA_W-1]) ? -src_b : src_b;
  assign b_zero    = (src_b == '0);

  // Extending both operands to 2W makes the truncated product correct signed or unsigned.
  assign ext_a   = {{DATA_W{signed_op & src_a[DATA_W-1]}}, src_a};
  assign ext_b   = {{DATA_W{signed_op & src_b[DATA_W-1]}}, src_b};
  assign product = ext_a * ext_b;
  assign mul_result = (MUL_STAGES == 1) ? product : mul_pipe[PIPE-1];

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = op_div && (b_zero || (abs_a < abs_b));
`else
  assign early_out = 1'b0;
`endif

  assign accept = start && !flush &&
                  ((state == ST_IDLE) || ((state == ST_DONE) && !is_busbusy));

  always_comb begin
    if (op_div) launch_state = early_out ? ST_DONE : ST_DIV;
    else        launch_state = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
  end

  ex_muldiv_unit_div_core #(
    .DATA_W   (DATA_W),
    .DIV_STEP (DIV_STEP)
  ) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && op_div),
    .en        (state == ST_DIV),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg_q     (signed_op & (src_a[DATA_W-1] ^ src_b[DATA_W-1])),
    .neg_r     (neg_a),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    res_hi    = '0;
    res_lo    = '0;
    res_dz    = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = launch_state;
      ST_MUL: begin
        if (flush) state_nxt = ST_IDLE;
        else if (mul_cnt_q == 2'd0) begin
          state_nxt = ST_DONE;
          complete  = 1'b1;
          {res_hi, res_lo} = mul_result;
        end
      end
      ST_DIV: begin
        if (flush) state_nxt = ST_IDLE;
        else if (div_done) begin
          state_nxt = ST_DONE;
          complete  = 1'b1;
          res_dz    = bz_q;
          res_hi    = bz_q ? a_q : div_rem;
          res_lo    = bz_q ? '1 : div_quo;
        end
      end
      ST_DONE: begin
        if (flush) state_nxt = ST_IDLE;
        else if (!is_busbusy) state_nxt = accept ? launch_state : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Single-stage multiply and early-out divides complete on the accepting edge.
    if (accept && (launch_state == ST_DONE)) begin
      complete = 1'b1;
      if (op_div) begin
        res_dz = b_zero;
        res_hi = src_a;
        res_lo = b_zero ? '1 : '0;
      end else begin
        {res_hi, res_lo} = product;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mul_cnt_q <= '0;
      a_q       <= '0;
      bz_q      <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      div_zero  <= 1'b0;
      for (int i = 0; i < PIPE; i++) mul_pipe[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mul_cnt_q   <= 2'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
        a_q         <= src_a;
        bz_q        <= b_zero;
        mul_pipe[0] <= product;
      end else if (state == ST_MUL) begin
        mul_cnt_q <= mul_cnt_q - 2'd1;
      end
      for (int i = 1; i < PIPE; i++) mul_pipe[i] <= mul_pipe[i-1];
      if (complete) begin
        hi_out   <= res_hi;
        lo_out   <= res_lo;
        div_zero <= res_dz;
      end
    end
  end

  assign busy        = (state == ST_MUL) || (state == ST_DIV);
  assign opreat_over = (state == ST_DONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit at default parameters; expected latencies
// follow MULDIV_EARLY_OUT_EN when it is defined for the build.
module tb_ex_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;
  localparam int DIV_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         reset, start, flush, is_busbusy;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, opreat_over, div_zero;
  logic [W-1:0] hi_out, lo_out;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  int proto_err = 0;

  ex_muldiv_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .is_busbusy  (is_busbusy),
    .busy        (busy),
    .opreat_over (opreat_over),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_zero    (div_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // The driver must never raise start while an op is in flight.
  always @(posedge clk) if (start && busy) proto_err++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
  endtask

  // Counts cycles from the accepting cycle until opreat_over; operands are scrambled after capture.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
      end
      lat++;
    end while (!opreat_over && lat < 200);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dz);
    int lat;
    launch(o, a, b);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; flush = 1'b0; is_busbusy = 1'b0;
    op = OP_MULT; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_over", 64'(opreat_over), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    run_op("mult",   OP_MULT,  32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu",  OP_MULTU, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div_neg", OP_DIV,  32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",   OP_DIVU,  32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_zero", OP_DIVU, 32'd5, 32'd0, EARLY_LAT, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div_m100", OP_DIV, 32'hFFFF_FF9C, 32'd7, DIV_LAT, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    run_op("divu_small", OP_DIVU, 32'd3, 32'd10, EARLY_LAT, 32'd3, 32'd0, 1'b0);

    // Flush ten cycles into a divide: no result, previous HI/LO kept.
    launch(OP_DIV, 32'd1000, 32'd3);
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (opreat_over) cnt++;
    end
    check("flush_no_over", 64'(cnt), 64'd0);
    check("flush_hi", 64'(hi_out), 64'd3);
    check("flush_lo", 64'(lo_out), 64'd0);

    // Stall for three cycles, then back-to-back op accepted in the release cycle.
    launch(OP_MULT, 32'd7, 32'd6);
    @(negedge clk); start = 1'b0; is_busbusy = 1'b1;
    check("bb_busy", 64'(busy), 64'd1);
    check("bb_over_early", 64'(opreat_over), 64'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (opreat_over) cnt++;
    end
    check("bb_lo", 64'(lo_out), 64'd42);
    check("bb_hi", 64'(hi_out), 64'd0);
    @(negedge clk);
    if (opreat_over) cnt++;
    check("bb_hold_cycles", 64'(cnt), 64'd4);
    is_busbusy = 1'b0; op = OP_MULTU; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("b2b_gap_over", 64'(opreat_over), 64'd0);
    check("b2b_gap_busy", 64'(busy), 64'd1);
    check("b2b_hold_lo", 64'(lo_out), 64'd42);
    @(negedge clk);
    check("b2b_over", 64'(opreat_over), 64'd1);
    check("b2b_lo", 64'(lo_out), 64'd25);

    // flush and start together in IDLE: start dropped.
    @(negedge clk); op = OP_MULT; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("fs_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    check("fs_over", 64'(opreat_over), 64'd0);
    check("fs_lo", 64'(lo_out), 64'd25);

    // flush while stalled in DONE drops opreat_over on the next edge.
    launch(OP_MULT, 32'd2, 32'd3);
    @(negedge clk); start = 1'b0; is_busbusy = 1'b1;
    @(negedge clk);
    check("fd_over", 64'(opreat_over), 64'd1);
    @(negedge clk);
    check("fd_over_held", 64'(opreat_over), 64'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; is_busbusy = 1'b0;
    check("fd_over_drop", 64'(opreat_over), 64'd0);
    check("fd_lo", 64'(lo_out), 64'd6);

    // Asynchronous reset in the middle of a divide.
    launch(OP_DIV, 32'd100, 32'd7);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_over", 64'(opreat_over), 64'd0);
    check("mid_rst_lo", 64'(lo_out), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk); reset = 1'b0;
    run_op("post_rst", OP_MULT, 32'd3, 32'd4, 2, 32'd0, 32'd12, 1'b0);

    check("protocol", 64'(proto_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
